// File: rtl/spm_port_arbiter.sv
// spm_port_arbiter: shares the scratchpad data port between the CPU memory
// stage (port C) and the debug/loader engine (port D). Grants are decided
// combinationally from the requests and registered state. Read data comes
// back one cycle later and is steered to whichever port issued the read.
//
// Handshake: a requester raises *_req with its operands and holds them
// stable until it sees *_gnt in the same cycle. A cycle with req && gnt is
// one completed transfer. A C request without a grant raises c_stall.
module spm_port_arbiter #(
  parameter int WAIT_LIMIT = 4,
  parameter int MAX_BURST  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_req,
  input  logic        c_rw,
  input  logic [29:0] c_addr,
  input  logic [31:0] c_wr_data,
  output logic        c_gnt,
  output logic        c_stall,
  output logic [31:0] c_rd_data,
  input  logic        d_req,
  input  logic        d_lock,
  input  logic        d_rw,
  input  logic [29:0] d_addr,
  input  logic [31:0] d_wr_data,
  output logic        d_gnt,
  output logic        d_rd_valid,
  output logic [31:0] d_rd_data,
  output logic        spm_as_,
  output logic        spm_rw,
  output logic [29:0] spm_addr,
  output logic [31:0] spm_wr_data,
  input  logic [31:0] spm_rd_data,
  output logic        dbg_state_o
);

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  localparam int WAIT_W  = $clog2(WAIT_LIMIT + 1);
  localparam int BURST_W = $clog2(MAX_BURST + 1);

  localparam logic [WAIT_W-1:0]  WAIT_MAX  = WAIT_W'(WAIT_LIMIT);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t             state_q;
  logic [WAIT_W-1:0]  wait_cnt_q;
  logic [BURST_W-1:0] burst_cnt_q;
  logic [BURST_W-1:0] burst_cnt_d;
  logic               c_first_q;
  logic               rd_pend_q;
  logic               rd_owner_q;   // 0 = C, 1 = D

  logic wait_hit;
  logic burst_go;
  logic burst_release;
  logic rd_granted;

  // A locked burst keeps the port while D asks for it; otherwise it falls
  // back to normal arbitration in the same cycle so the port never idles.
  assign burst_go = (state_q == ST_BURST) && d_req && d_lock;
  // D has waited long enough that it must be served this cycle.
  assign wait_hit = d_req && (wait_cnt_q == WAIT_MAX);

  // Grant selection: burst beat, then the forced C cycle after a burst
  // release, then the D starvation override, then C priority, then D.
  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (burst_go) begin
      d_gnt = 1'b1;
    end else if (c_first_q && c_req) begin
      c_gnt = 1'b1;
    end else if (wait_hit) begin
      d_gnt = 1'b1;
    end else if (c_req) begin
      c_gnt = 1'b1;
    end else if (d_req) begin
      d_gnt = 1'b1;
    end
  end

  // Beat count after the current burst beat, saturating at MAX_BURST; the
  // burst yields to C once that count reaches MAX_BURST with C waiting.
  always_comb begin
    burst_cnt_d = (burst_cnt_q == BURST_MAX) ? BURST_MAX
                                             : burst_cnt_q + BURST_W'(1);
    burst_release = (burst_cnt_d == BURST_MAX) && c_req;
  end

  assign rd_granted = (c_gnt && (c_rw == READ)) || (d_gnt && (d_rw == READ));

  // Arbitration FSM with its wait/burst counters and the forced-C flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_ARB;
      wait_cnt_q  <= '0;
      burst_cnt_q <= '0;
      c_first_q   <= 1'b0;
    end else begin
      c_first_q <= 1'b0;

      if (!d_req || d_gnt) begin
        wait_cnt_q <= '0;
      end else if (wait_cnt_q != WAIT_MAX) begin
        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
      end

      if (burst_go) begin
        if (burst_release) begin
          state_q     <= ST_ARB;
          burst_cnt_q <= '0;
          c_first_q   <= 1'b1;
        end else begin
          state_q     <= ST_BURST;
          burst_cnt_q <= burst_cnt_d;
        end
      end else if (d_gnt && d_lock) begin
        // Opening beat of a burst; a one-beat limit releases immediately.
        if ((BURST_MAX == BURST_W'(1)) && c_req) begin
          state_q     <= ST_ARB;
          burst_cnt_q <= '0;
          c_first_q   <= 1'b1;
        end else begin
          state_q     <= ST_BURST;
          burst_cnt_q <= BURST_W'(1);
        end
      end else begin
        state_q     <= ST_ARB;
        burst_cnt_q <= '0;
      end
    end
  end

  // Remember who issued the read so next cycle's SPM data goes to them.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      rd_pend_q <= rd_granted;
      if (rd_granted) begin
        rd_owner_q <= d_gnt;
      end
    end
  end

  // SPM port mux: granted requester's operands, or an idle read of 0.
  always_comb begin
    spm_rw      = READ;
    spm_addr    = '0;
    spm_wr_data = '0;
    if (c_gnt) begin
      spm_rw      = c_rw;
      spm_addr    = c_addr;
      spm_wr_data = c_wr_data;
    end else if (d_gnt) begin
      spm_rw      = d_rw;
      spm_addr    = d_addr;
      spm_wr_data = d_wr_data;
    end
  end

  assign spm_as_     = !(c_gnt || d_gnt);
  assign c_stall     = c_req && !c_gnt;
  assign d_rd_valid  = rd_pend_q && rd_owner_q;
  assign c_rd_data   = (rd_pend_q && !rd_owner_q) ? spm_rd_data : 32'h0;
  assign d_rd_data   = d_rd_valid ? spm_rd_data : 32'h0;
  assign dbg_state_o = (state_q == ST_BURST);

  // WRITE is named for readability of the direction encoding only.
  logic unused_write;
  assign unused_write = WRITE;

endmodule

// File: tb/tb_spm_port_arbiter.sv
// Bench for spm_port_arbiter: a table of per-cycle request vectors with
// hand-derived grant expectations, a small SPM read model, and a queue of
// expected read returns checked on the following cycle.
module tb_spm_port_arbiter;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  logic        clk = 1'b0;
  logic        reset;
  logic        c_req, c_rw;
  logic [29:0] c_addr;
  logic [31:0] c_wr_data;
  logic        c_gnt, c_stall;
  logic [31:0] c_rd_data;
  logic        d_req, d_lock, d_rw;
  logic [29:0] d_addr;
  logic [31:0] d_wr_data;
  logic        d_gnt, d_rd_valid;
  logic [31:0] d_rd_data;
  logic        spm_as_, spm_rw;
  logic [29:0] spm_addr;
  logic [31:0] spm_wr_data;
  logic [31:0] spm_rd_data;
  logic        dbg_state_o;

  spm_port_arbiter #(.WAIT_LIMIT(4), .MAX_BURST(8)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_rw(c_rw), .c_addr(c_addr), .c_wr_data(c_wr_data),
    .c_gnt(c_gnt), .c_stall(c_stall), .c_rd_data(c_rd_data),
    .d_req(d_req), .d_lock(d_lock), .d_rw(d_rw), .d_addr(d_addr),
    .d_wr_data(d_wr_data), .d_gnt(d_gnt), .d_rd_valid(d_rd_valid),
    .d_rd_data(d_rd_data), .spm_as_(spm_as_), .spm_rw(spm_rw),
    .spm_addr(spm_addr), .spm_wr_data(spm_wr_data),
    .spm_rd_data(spm_rd_data), .dbg_state_o(dbg_state_o)
  );

  // Clock
  always #5 clk = ~clk;

  // Word stored at each SPM address, and the write data each port sends.
  function automatic logic [31:0] spm_word(input logic [29:0] a);
    return {a, 2'b11} ^ 32'h5A5A_1234;
  endfunction
  function automatic logic [31:0] c_wd(input logic [29:0] a);
    return {2'b01, a} ^ 32'h0C0D_E000;
  endfunction
  function automatic logic [31:0] d_wd(input logic [29:0] a);
    return {2'b10, a} ^ 32'h000D_00D0;
  endfunction

  // SPM model: one-cycle read latency, random junk when no read was strobed.
  always @(posedge clk) begin
    if (!spm_as_ && spm_rw == READ) spm_rd_data <= spm_word(spm_addr);
    else                            spm_rd_data <= $urandom;
  end

  typedef struct packed {
    logic        c_req;
    logic        c_rw;
    logic [29:0] c_addr;
    logic        d_req;
    logic        d_lock;
    logic        d_rw;
    logic [29:0] d_addr;
    logic        rst;
    logic        eg_c;
    logic        eg_d;
    logic        st_chk;
    logic        st_exp;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] exp_q[$];
  logic        own_q[$];
  int          n_vec  = 0;
  int          n_cmp  = 0;
  int          n_miss = 0;

  function automatic vec_t mk(input logic cr, input logic crw, input logic [29:0] ca,
                              input logic dr, input logic dl, input logic drw,
                              input logic [29:0] da, input logic egc, input logic egd);
    vec_t v;
    v.c_req = cr;  v.c_rw = crw;  v.c_addr = ca;
    v.d_req = dr;  v.d_lock = dl; v.d_rw = drw; v.d_addr = da;
    v.rst = 1'b0;  v.eg_c = egc;  v.eg_d = egd;
    v.st_chk = 1'b0; v.st_exp = 1'b0;
    return v;
  endfunction

  task automatic cmp(input int idx, input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL v%0d %s: got %h expected %h", idx, nm, act, exp);
    end
  endtask

  // Driver
  task automatic drive(input vec_t v);
    reset     = v.rst;
    c_req     = v.c_req;
    c_rw      = v.c_rw;
    c_addr    = v.c_addr;
    c_wr_data = c_wd(v.c_addr);
    d_req     = v.d_req;
    d_lock    = v.d_lock;
    d_rw      = v.d_rw;
    d_addr    = v.d_addr;
    d_wr_data = d_wd(v.d_addr);
  endtask

  // Scoreboard check for one cycle, sampled at the falling edge.
  task automatic check(input int idx, input vec_t v);
    logic [31:0] e;
    logic        o;
    logic        e_rw;
    logic [29:0] e_addr;
    logic [31:0] e_wd;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = own_q.pop_front();
      cmp(idx, "d_rd_valid", {31'b0, d_rd_valid}, {31'b0, o});
      cmp(idx, "c_rd_data", c_rd_data, o ? 32'h0 : e);
      cmp(idx, "d_rd_data", d_rd_data, o ? e : 32'h0);
    end else begin
      cmp(idx, "d_rd_valid_idle", {31'b0, d_rd_valid}, 32'h0);
      cmp(idx, "c_rd_data_idle", c_rd_data, 32'h0);
      cmp(idx, "d_rd_data_idle", d_rd_data, 32'h0);
    end
    cmp(idx, "c_gnt", {31'b0, c_gnt}, {31'b0, v.eg_c});
    cmp(idx, "d_gnt", {31'b0, d_gnt}, {31'b0, v.eg_d});
    cmp(idx, "c_stall", {31'b0, c_stall}, {31'b0, v.c_req & ~v.eg_c});
    cmp(idx, "spm_as_", {31'b0, spm_as_}, {31'b0, ~(v.eg_c | v.eg_d)});
    e_rw = READ; e_addr = '0; e_wd = '0;
    if (v.eg_c) begin
      e_rw = v.c_rw; e_addr = v.c_addr; e_wd = c_wd(v.c_addr);
    end else if (v.eg_d) begin
      e_rw = v.d_rw; e_addr = v.d_addr; e_wd = d_wd(v.d_addr);
    end
    cmp(idx, "spm_rw", {31'b0, spm_rw}, {31'b0, e_rw});
    cmp(idx, "spm_addr", {2'b0, spm_addr}, {2'b0, e_addr});
    cmp(idx, "spm_wr_data", spm_wr_data, e_wd);
    if (v.st_chk) cmp(idx, "state", {31'b0, dbg_state_o}, {31'b0, v.st_exp});
    if (!v.rst && v.eg_c && v.c_rw == READ) begin
      exp_q.push_back(spm_word(v.c_addr)); own_q.push_back(1'b0);
    end
    if (!v.rst && v.eg_d && v.d_rw == READ) begin
      exp_q.push_back(spm_word(v.d_addr)); own_q.push_back(1'b1);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    @(posedge clk); #1;
    drive(v);
    @(negedge clk);
    check(idx, v);
    n_vec++;
  endtask

  vec_t v;
  int   nc, nd;
  logic gd;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Clock/reset block
    drive(mk(0, READ, '0, 0, 0, READ, '0, 0, 0));
    reset = 1'b1;
    repeat (3) @(posedge clk);

    // Reset state, then a C read at 0x10 and its return.
    v = mk(0, READ, '0, 0, 0, READ, '0, 0, 0); v.st_chk = 1'b1; v.st_exp = 1'b0;
    tbl.push_back(v);
    tbl.push_back(mk(1, READ, 30'h10, 0, 0, READ, '0, 1, 0));
    tbl.push_back(mk(0, READ, '0, 0, 0, READ, '0, 0, 0));

    // Contention: C granted 4 cycles, then D forced for 1, repeating.
    nc = 0; nd = 0;
    for (int i = 0; i < 10; i++) begin
      gd = ((i % 5) == 4);
      tbl.push_back(mk(1, READ, 30'(32'h100 + nc), 1, 0, READ, 30'(32'h200 + nd), !gd, gd));
      if (gd) nd++; else nc++;
    end
    tbl.push_back(mk(0, READ, '0, 0, 0, READ, '0, 0, 0));

    // Locked 12-beat write burst with a stalled C read: 8 D, 1 C, 4 D.
    tbl.push_back(mk(0, READ, '0, 1, 1, WRITE, 30'h300, 0, 1));
    for (int i = 1; i < 8; i++) begin
      v = mk(1, READ, 30'h40, 1, 1, WRITE, 30'(32'h300 + i), 0, 1);
      if (i == 1) begin v.st_chk = 1'b1; v.st_exp = 1'b1; end
      tbl.push_back(v);
    end
    v = mk(1, READ, 30'h40, 1, 1, WRITE, 30'h308, 1, 0); v.st_chk = 1'b1; v.st_exp = 1'b0;
    tbl.push_back(v);
    for (int i = 8; i < 12; i++) begin
      v = mk(0, READ, '0, 1, 1, WRITE, 30'(32'h300 + i), 0, 1);
      if (i == 10) begin v.st_chk = 1'b1; v.st_exp = 1'b1; end
      tbl.push_back(v);
    end
    tbl.push_back(mk(0, READ, '0, 0, 0, READ, '0, 0, 0));

    // Same burst without C: 12 consecutive D grants, past the beat limit.
    for (int i = 0; i < 12; i++)
      tbl.push_back(mk(0, READ, '0, 1, 1, WRITE, 30'(32'h400 + i), 0, 1));
    tbl.push_back(mk(0, READ, '0, 0, 0, READ, '0, 0, 0));

    // Read routing: D read at the top address, then a C write.
    tbl.push_back(mk(0, READ, '0, 1, 0, READ, 30'h3FFF_FFFF, 0, 1));
    tbl.push_back(mk(1, WRITE, 30'h55, 0, 0, READ, '0, 1, 0));
    tbl.push_back(mk(0, READ, '0, 0, 0, READ, '0, 0, 0));

    // Reset on the cycle of a locked D read: burst and return are dropped.
    v = mk(0, READ, '0, 1, 1, READ, 30'h600, 0, 1); v.rst = 1'b1;
    tbl.push_back(v);
    v = mk(0, READ, '0, 0, 0, READ, '0, 0, 0); v.st_chk = 1'b1; v.st_exp = 1'b0;
    tbl.push_back(v);
    tbl.push_back(mk(1, READ, 30'h20, 1, 1, READ, 30'h601, 1, 0));
    tbl.push_back(mk(0, READ, '0, 0, 0, READ, '0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) run_vec(i, tbl[i]);

    // Every queued read return must have been consumed.
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL leftover_reads: got %0d expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
